// File: rtl/control_unit.sv
// Microsequencer for a small LC-3 style datapath: fetch/decode/execute FSM whose
// control outputs are a pure decode of the current state (plus memory ready).
module control_unit #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        i_CLK,
    input  logic        i_RST_N,
    input  logic [15:0] i_IR,
    input  logic [2:0]  i_NZP,
    input  logic        i_MEM_R,
    output logic        o_LD_MAR,
    output logic        o_LD_MDR,
    output logic        o_LD_IR,
    output logic        o_LD_PC,
    output logic        o_LD_REG,
    output logic        o_LD_CC,
    output logic        o_GatePC,
    output logic        o_GateMDR,
    output logic        o_GateALU,
    output logic        o_GateMARMUX,
    output logic [1:0]  o_PCMUX,
    output logic        o_ADDR1MUX,
    output logic [1:0]  o_ADDR2MUX,
    output logic [1:0]  o_ALUK,
    output logic [1:0]  o_SR1MUX,
    output logic [1:0]  o_DRMUX,
    output logic        o_MIO_EN,
    output logic        o_R_W,
    output logic        o_HALT,
    output logic [5:0]  o_STATE
);

    localparam logic [5:0] S0      = 6'd0;
    localparam logic [5:0] S1      = 6'd1;
    localparam logic [5:0] S2      = 6'd2;
    localparam logic [5:0] S3      = 6'd3;
    localparam logic [5:0] S5      = 6'd5;
    localparam logic [5:0] S9      = 6'd9;
    localparam logic [5:0] S12     = 6'd12;
    localparam logic [5:0] S14     = 6'd14;
    localparam logic [5:0] S16     = 6'd16;
    localparam logic [5:0] S18     = 6'd18;
    localparam logic [5:0] S22     = 6'd22;
    localparam logic [5:0] S23     = 6'd23;
    localparam logic [5:0] S25     = 6'd25;
    localparam logic [5:0] S27     = 6'd27;
    localparam logic [5:0] S32     = 6'd32;
    localparam logic [5:0] S33     = 6'd33;
    localparam logic [5:0] S35     = 6'd35;
    localparam logic [5:0] ST_HALT = 6'd63;

    logic [5:0] state;
    logic [5:0] next_state;
    logic       ben;
    logic       unused_ir_bits;

    // Only the opcode and the branch condition field steer sequencing.
    assign unused_ir_bits = ^i_IR[8:0];

    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            state <= S18;
            ben   <= 1'b0;
        end else begin
            state <= next_state;
            if (state == S32) begin
                ben <= |(i_IR[11:9] & i_NZP);
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S18:                          next_state = S33;
            S33:                          next_state = i_MEM_R ? S35 : S33;
            S35:                          next_state = S32;
            S32: begin
                case (i_IR[15:12])
                    4'b0001: next_state = S1;
                    4'b0101: next_state = S5;
                    4'b1001: next_state = S9;
                    4'b1110: next_state = S14;
                    4'b0000: next_state = S0;
                    4'b1100: next_state = S12;
                    4'b0010: next_state = S2;
                    4'b0011: next_state = S3;
                    default: next_state = HALT_ON_ILLEGAL ? ST_HALT : S18;
                endcase
            end
            S1, S5, S9, S14, S22, S12, S27: next_state = S18;
            S0:                           next_state = ben ? S22 : S18;
            S2:                           next_state = S25;
            S3:                           next_state = S23;
            S25:                          next_state = i_MEM_R ? S27 : S25;
            S23:                          next_state = S16;
            S16:                          next_state = i_MEM_R ? S18 : S16;
            ST_HALT:                      next_state = ST_HALT;
            default:                      next_state = S18;
        endcase
    end

    // Reset gates every output low combinationally, so an in-flight access drops at once.
    always_comb begin
        o_LD_MAR     = 1'b0;
        o_LD_MDR     = 1'b0;
        o_LD_IR      = 1'b0;
        o_LD_PC      = 1'b0;
        o_LD_REG     = 1'b0;
        o_LD_CC      = 1'b0;
        o_GatePC     = 1'b0;
        o_GateMDR    = 1'b0;
        o_GateALU    = 1'b0;
        o_GateMARMUX = 1'b0;
        o_PCMUX      = 2'b00;
        o_ADDR1MUX   = 1'b0;
        o_ADDR2MUX   = 2'b00;
        o_ALUK       = 2'b00;
        o_SR1MUX     = 2'b00;
        o_DRMUX      = 2'b00;
        o_MIO_EN     = 1'b0;
        o_R_W        = 1'b0;
        o_HALT       = 1'b0;
        o_STATE      = 6'd0;
        if (i_RST_N) begin
            o_STATE = state;
            case (state)
                S18: begin
                    o_GatePC = 1'b1;
                    o_LD_MAR = 1'b1;
                    o_LD_PC  = 1'b1;
                end
                S33, S25: begin
                    o_MIO_EN = 1'b1;
                    o_LD_MDR = i_MEM_R;
                end
                S35: begin
                    o_GateMDR = 1'b1;
                    o_LD_IR   = 1'b1;
                end
                S1, S5, S9: begin
                    o_SR1MUX  = 2'b01;
                    o_ALUK    = (state == S1) ? 2'b00 : ((state == S5) ? 2'b01 : 2'b10);
                    o_GateALU = 1'b1;
                    o_LD_REG  = 1'b1;
                    o_LD_CC   = 1'b1;
                end
                S14: begin
                    o_ADDR2MUX   = 2'b10;
                    o_GateMARMUX = 1'b1;
                    o_LD_REG     = 1'b1;
                end
                S22: begin
                    o_ADDR2MUX = 2'b10;
                    o_PCMUX    = 2'b10;
                    o_LD_PC    = 1'b1;
                end
                S12: begin
                    o_SR1MUX   = 2'b01;
                    o_ADDR1MUX = 1'b1;
                    o_PCMUX    = 2'b10;
                    o_LD_PC    = 1'b1;
                end
                S2, S3: begin
                    o_ADDR2MUX   = 2'b10;
                    o_GateMARMUX = 1'b1;
                    o_LD_MAR     = 1'b1;
                end
                S27: begin
                    o_GateMDR = 1'b1;
                    o_LD_REG  = 1'b1;
                    o_LD_CC   = 1'b1;
                end
                S23: begin
                    o_ALUK    = 2'b11;
                    o_GateALU = 1'b1;
                    o_LD_MDR  = 1'b1;
                end
                S16: begin
                    o_MIO_EN = 1'b1;
                    o_R_W    = 1'b1;
                end
                ST_HALT: o_HALT = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter HALT_ON_ILLEGAL, default 1: 1 = unsupported opcode enters HALT; 0 = treated as NOP.
REQ-002 i_CLK  in  1  sole clock, all state updates on rising edge.
REQ-003 i_RST_N  in  1  reset, synchronous, active-low.
REQ-004 i_IR  in  16  current instruction register contents.
REQ-005 i_NZP  in  3  condition codes {N,Z,P} from CC register.
REQ-006 i_MEM_R  in  1  memory ready; access completes in cycle it is 1.
REQ-007 o_LD_MAR, o_LD_MDR, o_LD_IR, o_LD_PC, o_LD_REG, o_LD_CC  out  1 each  register load enables.
REQ-008 o_GatePC, o_GateMDR, o_GateALU, o_GateMARMUX  out  1 each  bus drive enables.
REQ-009 o_PCMUX  out  2  00 PC+1, 01 bus, 10 address adder.
REQ-010 o_ADDR1MUX  out  1  0 PC, 1 SR1 output.
REQ-011 o_ADDR2MUX  out  2  00 zero, 01 SEXT offset6, 10 SEXT PCoffset9, 11 SEXT PCoffset11.
REQ-012 o_ALUK  out  2  00 ADD, 01 AND, 10 NOT, 11 PASS A.
REQ-013 o_SR1MUX  out  2  00 IR[11:9], 01 IR[8:6], 10 R6.
REQ-014 o_DRMUX  out  2  00 IR[11:9], 01 R6, 10 R7.
REQ-015 o_MIO_EN  out  1  memory access request; o_R_W  out  1  0 read, 1 write.
REQ-016 o_HALT  out  1  high while in HALT; o_STATE  out  6  current state number.

Function
REQ-017 Controller SHALL be a state machine with states S18, S33, S35, S32, S1, S5, S9, S14, S0, S22, S12, S2, S25, S27, S3, S23, S16, HALT; o_STATE = state number, HALT = 63.
REQ-018 Every output not named for a state SHALL be 0; at most one Gate output SHALL be 1 in any cycle.
REQ-019 S18: GatePC, LD_MAR, LD_PC, PCMUX=00 -> S33.
REQ-020 S33: MIO_EN, R_W=0; LD_MDR = i_MEM_R; stay while i_MEM_R=0, else -> S35.
REQ-021 S35: GateMDR, LD_IR -> S32.
REQ-022 S32: no loads; latch BEN = (IR[11]&N)|(IR[10]&Z)|(IR[9]&P); next by IR[15:12]: 0001 S1, 0101 S5, 1001 S9, 1110 S14, 0000 S0, 1100 S12, 0010 S2, 0011 S3, other HALT (or S18 if HALT_ON_ILLEGAL=0).
REQ-023 S1/S5/S9: SR1MUX=01, ALUK=00/01/10, GateALU, LD_REG, DRMUX=00, LD_CC -> S18.
REQ-024 S14 (LEA): ADDR1MUX=0, ADDR2MUX=10, GateMARMUX, LD_REG, DRMUX=00, LD_CC=0 -> S18.
REQ-025 S0: BEN=1 -> S22, else -> S18; S22: ADDR1MUX=0, ADDR2MUX=10, PCMUX=10, LD_PC -> S18.
REQ-026 S12 (JMP): SR1MUX=01, ADDR1MUX=1, ADDR2MUX=00, PCMUX=10, LD_PC -> S18.
REQ-027 S2/S3: ADDR1MUX=0, ADDR2MUX=10, GateMARMUX, LD_MAR -> S25 / S23.
REQ-028 S25: as S33 (read, LD_MDR = i_MEM_R, wait) -> S27; S27: GateMDR, LD_REG, DRMUX=00, LD_CC -> S18.
REQ-029 S23: SR1MUX=00, ALUK=11, GateALU, LD_MDR -> S16; S16: MIO_EN, R_W=1, wait while i_MEM_R=0 -> S18.
REQ-030 HALT: o_HALT=1, all loads/gates/MIO_EN 0, remains until reset.
REQ-031 Outputs SHALL be combinational decode of state (plus i_MEM_R in S33/S25); no wait-state timeout.

Reset
REQ-032 While i_RST_N=0 all outputs SHALL be forced 0 and state SHALL load S18 on each edge, BEN cleared; reset mid-access aborts it.
REQ-033 First cycle after i_RST_N rises SHALL be S18.

Verification
REQ-034 Reset then i_MEM_R=1, IR=0x1283 (ADD R1,R2,R3) -> states 18,33,35,32,1; in S1 SR1MUX=01, ALUK=00, LD_REG=1, LD_CC=1, GateALU=1.
REQ-035 i_MEM_R held 0 for 3 cycles in S33 -> state stays 33, LD_MDR=0; rises -> LD_MDR=1 same cycle, next S35.
REQ-036 IR=0x0402 (BRz), i_NZP=010 -> S0 then S22 with LD_PC=1, PCMUX=10; i_NZP=100 -> S0 then S18.
REQ-037 IR=0x3205 (ST R1) -> 3,23,16; in S23 ALUK=11, SR1MUX=00, LD_MDR=1; S16 R_W=1, MIO_EN=1 until i_MEM_R.
REQ-038 IR=0xF025 -> HALT, o_STATE=63, o_HALT=1 held; i_RST_N=0 one cycle -> S18, o_HALT=0.
REQ-039 i_RST_N=0 asserted in S25 -> all outputs 0 immediately, S18 after release.
